k_sort: RTL and testbench
=========================

Name: k_sort

Overview:
- Upstream producer for the K-NN type-inference stage. It accepts a stream of (distance, type) samples, one per cycle, and keeps a sorted list of the K smallest distances.
- On the sample flagged last, it publishes the K neighbour types as a packed array, together with a one-cycle valid_sort pulse.
- It sits between the distance calculator and the type-inference block. It drives that block's k_nearest_neighbours_type and valid_sort inputs directly.

Parameters:
- K, 4, number of nearest neighbours kept (K >= 1).
- TYPE_W, 2, width of a neighbour type/class label.
- DIST_W, 8, width of an unsigned distance.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_valid  input  1  sample_distance/sample_type/sample_last are valid.
- sample_last  input  1  marks the final sample of the current query.
- sample_distance  input  DIST_W  unsigned distance of the sample.
- sample_type  input  TYPE_W  type label of the sample.
- sample_ready  output  1  block can accept a sample this cycle.
- k_nearest_neighbours_type  output  TYPE_W*K  packed types, slot j at bits [(j+1)*TYPE_W-1 -: TYPE_W]; slot 0 is nearest.
- k_nearest_neighbours_distance  output  DIST_W*K  packed distances, same slot layout.
- neighbour_count  output  $clog2(K+1)  number of occupied slots in the published list.
- valid_sort  output  1  one-cycle pulse: published outputs updated.

Behaviour:
- Accept rule: a sample is accepted on a clock edge where sample_valid && sample_ready.
- State machine has three states: IDLE, COLLECT, PUBLISH.
  - IDLE: sample_ready=1. An accepted sample is inserted. If sample_last=1, next state is PUBLISH; otherwise COLLECT.
  - COLLECT: sample_ready=1. An accepted sample is inserted. If sample_last=1, next state is PUBLISH.
  - PUBLISH: sample_ready=0; sample_valid is ignored. On the exit edge:
    - published outputs <= working list, including the last sample;
    - neighbour_count <= occupied slot count;
    - valid_sort <= 1;
    - working list cleared;
    - next state IDLE.
- valid_sort is 1 for exactly one cycle after PUBLISH, and is 0 otherwise.
- Latency: last sample accepted at edge N -> valid_sort high between edges N+1 and N+2.
- Throughput: one accepted sample per cycle, with one bubble cycle per query.
- Working list: K slots, each holding {occupied, distance, type}, sorted ascending by distance, with occupied slots first.
- Insertion of an accepted sample (single cycle, parallel compare-shift):
  - Insert position p = number of occupied slots whose distance <= sample_distance. Ties are stable: the new sample goes after existing equal distances.
  - Slots p..K-2 shift down by one; slot K-1 is dropped.
  - If p == K, the sample is discarded.
  - Occupancy is tracked by the occupied bit, not by a sentinel. A sample with distance all-ones is still inserted into an empty slot.
- Unoccupied published slots read type 0 and distance all-ones.
- Published outputs and neighbour_count are held stable until the next valid_sort. The new query's samples do not disturb them. This keeps the array stable while the downstream block iterates over it.
- Spacing is a system rule, not enforced here: queries shorter than the downstream block's processing time (K + 2^TYPE_W + 3 cycles) are not allowed.
- Reset values:
  - sample_ready=0 during reset, 1 after;
  - valid_sort=0, neighbour_count=0;
  - all published types 0, all published distances all-ones;
  - working list empty;
  - state IDLE.
- Reset mid-query discards all accepted samples. No valid_sort is produced for that query.
- Single-sample query (sample_last on the first sample) is legal: neighbour_count=1.
- More than K samples: only the K smallest are kept. neighbour_count saturates at K.

Decomposition:
- Shared package k_nn_pkg holds:
  - default K/TYPE_W/DIST_W constants;
  - state encoding localparams (IDLE=2'b00, COLLECT=2'b01, PUBLISH=2'b10);
  - the packed slot-indexing function shared with the type-inference block.
- One sub-module is natural: k_sort_slot, one list entry. Inputs are its neighbour-above slot, the new sample, and compare results; it outputs its next {occupied, distance, type}. It is instantiated K times in a generate loop.

Test Plan (K=4, TYPE_W=2, DIST_W=8):
- Basic sort and ties:
  - Stimulus: samples (50,1),(10,2),(30,3),(10,0),(70,1,last) back-to-back.
  - Required: valid_sort one cycle after PUBLISH; types packed = 8'h72 (slots 2,0,3,1); distances packed = 32'h32_1E_0A_0A; neighbour_count=4; sample_ready=0 exactly one cycle.
- Short query:
  - Stimulus: (20,3),(5,1,last).
  - Required: types = 8'h0D; distances = 32'hFF_FF_14_05; neighbour_count=2.
- Full-scale distance and single-sample query:
  - Stimulus: (255,2,last).
  - Required: slot0 type 2, distance 8'hFF; neighbour_count=1.
- Back-to-back queries:
  - Stimulus: query A from the first scenario, then query B (3,3),(4,1,last) starting the cycle valid_sort pulses.
  - Required: A's outputs held constant until B's valid_sort; B result types = 8'h07; neighbour_count=2.
- PUBLISH ignores input:
  - Stimulus: sample_valid=1 with (0,3) held during the PUBLISH cycle.
  - Required: sample not inserted into either query's list.
- Reset mid-query:
  - Stimulus: rst for one cycle after 2 of 5 samples, then a new query (9,1,last).
  - Required: no valid_sort for the aborted query; new result types = 8'h01, neighbour_count=1.

Source files
------------

// File: rtl/k_nn_pkg.sv
// Shared definitions for the K-NN pipeline: default sizes, sorter FSM states,
// and the packed slot-indexing helper also used by the type-inference block.
package k_nn_pkg;
  localparam int K_DEF      = 4;
  localparam int TYPE_W_DEF = 2;
  localparam int DIST_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    PUBLISH = 2'b10
  } state_t;

  // LSB of slot 'slot' in a packed array of 'width'-bit fields.
  function automatic int slot_lsb(input int slot, input int width);
    return slot * width;
  endfunction
endpackage

// File: rtl/k_sort_slot.sv
// One entry of the sorted neighbour list: chooses between holding its value,
// taking the incoming sample, or shifting down the entry from the slot above.
module k_sort_slot
  import k_nn_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF,
  parameter int TYPE_W = TYPE_W_DEF
) (
  input  logic              i_keep,
  input  logic              i_take_new,
  input  logic              i_cur_occ,
  input  logic [DIST_W-1:0] i_cur_dist,
  input  logic [TYPE_W-1:0] i_cur_type,
  input  logic              i_up_occ,
  input  logic [DIST_W-1:0] i_up_dist,
  input  logic [TYPE_W-1:0] i_up_type,
  input  logic [DIST_W-1:0] i_new_dist,
  input  logic [TYPE_W-1:0] i_new_type,
  output logic              o_occ,
  output logic [DIST_W-1:0] o_dist,
  output logic [TYPE_W-1:0] o_type
);
  // Keep bits form a prefix of ones, so the first non-keeping slot takes the
  // sample and every later slot shifts down.
  always_comb begin
    o_occ  = i_cur_occ;
    o_dist = i_cur_dist;
    o_type = i_cur_type;
    if (!i_keep) begin
      if (i_take_new) begin
        o_occ  = 1'b1;
        o_dist = i_new_dist;
        o_type = i_new_type;
      end else begin
        o_occ  = i_up_occ;
        o_dist = i_up_dist;
        o_type = i_up_type;
      end
    end
  end
endmodule

// File: rtl/k_sort.sv
// Streaming K-smallest sorter: inserts one (distance, type) sample per cycle
// and publishes the sorted list with a one-cycle valid_sort after the last one.
module k_sort
  import k_nn_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int TYPE_W = TYPE_W_DEF,
  parameter int DIST_W = DIST_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic                    sample_last,
  input  logic [DIST_W-1:0]       sample_distance,
  input  logic [TYPE_W-1:0]       sample_type,
  output logic                    sample_ready,
  output logic [TYPE_W*K-1:0]     k_nearest_neighbours_type,
  output logic [DIST_W*K-1:0]     k_nearest_neighbours_distance,
  output logic [$clog2(K+1)-1:0]  neighbour_count,
  output logic                    valid_sort
);
  localparam int CNT_W = $clog2(K+1);

  state_t                      r_state, w_state_nxt;
  logic                        w_ready, w_accept, w_pub;
  logic [K-1:0]                r_occ, w_occ_nxt, w_le;
  logic [K-1:0][DIST_W-1:0]    r_dist, w_dist_nxt, r_pub_dist;
  logic [K-1:0][TYPE_W-1:0]    r_type, w_type_nxt, r_pub_type;
  logic [CNT_W-1:0]            w_count, r_pub_cnt;
  logic                        r_valid;

  for (genvar j = 0; j < K; j++) begin : g_slot
    logic              w_up_occ, w_take_new;
    logic [DIST_W-1:0] w_up_dist;
    logic [TYPE_W-1:0] w_up_type;

    // Ties are stable: an equal existing distance keeps its place.
    assign w_le[j] = r_occ[j] && (r_dist[j] <= sample_distance);

    if (j == 0) begin : g_head
      assign w_up_occ   = 1'b0;
      assign w_up_dist  = '1;
      assign w_up_type  = '0;
      assign w_take_new = 1'b1;
    end else begin : g_body
      assign w_up_occ   = r_occ[j-1];
      assign w_up_dist  = r_dist[j-1];
      assign w_up_type  = r_type[j-1];
      assign w_take_new = w_le[j-1];
    end

    k_sort_slot #(.DIST_W(DIST_W), .TYPE_W(TYPE_W)) u_slot (
      .i_keep     (w_le[j]),
      .i_take_new (w_take_new),
      .i_cur_occ  (r_occ[j]),
      .i_cur_dist (r_dist[j]),
      .i_cur_type (r_type[j]),
      .i_up_occ   (w_up_occ),
      .i_up_dist  (w_up_dist),
      .i_up_type  (w_up_type),
      .i_new_dist (sample_distance),
      .i_new_type (sample_type),
      .o_occ      (w_occ_nxt[j]),
      .o_dist     (w_dist_nxt[j]),
      .o_type     (w_type_nxt[j])
    );

    assign k_nearest_neighbours_type[slot_lsb(j, TYPE_W) +: TYPE_W]     = r_pub_type[j];
    assign k_nearest_neighbours_distance[slot_lsb(j, DIST_W) +: DIST_W] = r_pub_dist[j];
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < K; i++) w_count = w_count + CNT_W'(r_occ[i]);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = (r_state == IDLE) || (r_state == COLLECT);
    w_accept    = sample_valid && w_ready;
    w_pub       = 1'b0;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = sample_last ? PUBLISH : COLLECT;
      COLLECT: if (w_accept && sample_last) w_state_nxt = PUBLISH;
      PUBLISH: begin
        w_pub       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_occ      <= '0;
      r_dist     <= '1;
      r_type     <= '0;
      r_pub_dist <= '1;
      r_pub_type <= '0;
      r_pub_cnt  <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_pub;
      if (w_pub) begin
        for (int i = 0; i < K; i++) begin
          r_pub_dist[i] <= r_occ[i] ? r_dist[i] : '1;
          r_pub_type[i] <= r_occ[i] ? r_type[i] : '0;
        end
        r_pub_cnt <= w_count;
        r_occ     <= '0;
        r_dist    <= '1;
        r_type    <= '0;
      end else if (w_accept) begin
        r_occ  <= w_occ_nxt;
        r_dist <= w_dist_nxt;
        r_type <= w_type_nxt;
      end
    end
  end

  assign sample_ready    = w_ready && !rst;
  assign neighbour_count = r_pub_cnt;
  assign valid_sort      = r_valid;
endmodule

// File: tb/tb_k_sort.sv
// Bench for k_sort: directed scenarios plus random queries, checked against a
// stable selection of the K smallest samples of each query.
module tb_k_sort;
  localparam int K      = 4;
  localparam int TYPE_W = 2;
  localparam int DIST_W = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   sample_valid = 1'b0, sample_last = 1'b0;
  logic [DIST_W-1:0]      sample_distance = '0;
  logic [TYPE_W-1:0]      sample_type = '0;
  logic                   sample_ready;
  logic [TYPE_W*K-1:0]    knn_type;
  logic [DIST_W*K-1:0]    knn_dist;
  logic [$clog2(K+1)-1:0] ncount;
  logic                   valid_sort;

  k_sort #(.K(K), .TYPE_W(TYPE_W), .DIST_W(DIST_W)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .sample_valid                  (sample_valid),
    .sample_last                   (sample_last),
    .sample_distance               (sample_distance),
    .sample_type                   (sample_type),
    .sample_ready                  (sample_ready),
    .k_nearest_neighbours_type     (knn_type),
    .k_nearest_neighbours_distance (knn_dist),
    .neighbour_count               (ncount),
    .valid_sort                    (valid_sort)
  );

  always #5 clk = ~clk;

  typedef struct { int d; int t; } samp_t;
  samp_t q[$];
  logic [K-1:0][TYPE_W-1:0] exp_type;
  logic [K-1:0][DIST_W-1:0] exp_dist;
  int exp_cnt;
  int passed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total = total + 1;
    assert (obs === expv) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    q.delete();
    exp_type = '0;
    exp_dist = '1;
    exp_cnt  = 0;
  endtask

  // K smallest of the query, earliest arrival first among equal distances.
  task automatic model_publish();
    bit used[64];
    exp_cnt = 0;
    foreach (used[i]) used[i] = 1'b0;
    for (int j = 0; j < K; j++) begin
      int best = -1;
      for (int i = 0; i < q.size(); i++)
        if (!used[i] && (best < 0 || q[i].d < q[best].d)) best = i;
      if (best >= 0) begin
        used[best]  = 1'b1;
        exp_type[j] = TYPE_W'(q[best].t);
        exp_dist[j] = DIST_W'(q[best].d);
        exp_cnt++;
      end else begin
        exp_type[j] = '0;
        exp_dist[j] = '1;
      end
    end
    q.delete();
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_vs"},   32'(valid_sort), 32'd0);
    chk({tag, "_type"}, 32'(knn_type), 32'(exp_type));
    chk({tag, "_dist"}, knn_dist, exp_dist);
    chk({tag, "_cnt"},  32'(ncount), 32'(exp_cnt));
  endtask

  task automatic publish_step();
    chk("pub_ready", 32'(sample_ready), 32'd0);
    chk("pub_vs_pre", 32'(valid_sort), 32'd0);
    // Junk sample offered during the bubble must be ignored.
    sample_valid = 1'b1; sample_distance = 8'd0; sample_type = 2'd3; sample_last = 1'b0;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    model_publish();
    chk("pub_vs",   32'(valid_sort), 32'd1);
    chk("pub_type", 32'(knn_type), 32'(exp_type));
    chk("pub_dist", knn_dist, exp_dist);
    chk("pub_cnt",  32'(ncount), 32'(exp_cnt));
  endtask

  task automatic send(input int d, input int t, input bit last);
    chk("ready", 32'(sample_ready), 32'd1);
    sample_valid = 1'b1; sample_distance = DIST_W'(d); sample_type = TYPE_W'(t);
    sample_last = last;
    @(posedge clk); #1;
    q.push_back('{d: d, t: t});
    sample_valid = 1'b0; sample_last = 1'b0;
    chk_held("hold");
    if (last) publish_step();
  endtask

  task automatic idle_cycle();
    sample_valid = 1'b0;
    @(posedge clk); #1;
    chk_held("idle");
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    chk("rst_ready", 32'(sample_ready), 32'd0);
    @(posedge clk); #1;
    chk_held("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(sample_ready), 32'd1);

    // Basic sort with ties, then query B starting on the valid_sort cycle.
    send(50, 1, 0); send(10, 2, 0); send(30, 3, 0); send(10, 0, 0); send(70, 1, 1);
    chk("s1_type", 32'(knn_type), 32'h72);
    chk("s1_dist", knn_dist, 32'h32_1E_0A_0A);
    chk("s1_cnt",  32'(ncount), 32'd4);
    send(3, 3, 0); send(4, 1, 1);
    chk("b_type", 32'(knn_type), 32'h07);
    chk("b_cnt",  32'(ncount), 32'd2);
    idle_cycle();

    // Short query.
    send(20, 3, 0); send(5, 1, 1);
    chk("s2_type", 32'(knn_type), 32'h0D);
    chk("s2_dist", knn_dist, 32'hFF_FF_14_05);
    chk("s2_cnt",  32'(ncount), 32'd2);
    idle_cycle();

    // Single full-scale sample.
    send(255, 2, 1);
    chk("s3_type", 32'(knn_type), 32'h02);
    chk("s3_dist", knn_dist, 32'hFF_FF_FF_FF);
    chk("s3_cnt",  32'(ncount), 32'd1);
    idle_cycle();

    // Reset mid-query discards the partial query.
    send(40, 1, 0); send(41, 2, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(sample_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk_held("mid_rst");
    idle_cycle(); idle_cycle();
    send(9, 1, 1);
    chk("s6_type", 32'(knn_type), 32'h01);
    chk("s6_cnt",  32'(ncount), 32'd1);

    // Random queries with heavy ties, full-scale distances and idle gaps.
    for (int qi = 0; qi < 40; qi++) begin
      int len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        int d = ($urandom_range(0, 4) == 0) ? 255 : $urandom_range(0, 20);
        if ($urandom_range(0, 4) == 0) idle_cycle();
        send(d, $urandom_range(0, 3), i == len - 1);
      end
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
